rr_mux_mxn: RTL and testbench

- Parametrised, registered N:1 multiplexer with a valid/ready handshake on every input channel and on the output.
- Two modes: round-robin arbitration across all requesting channels, or fixed selection by an explicit select bus (classic mux behaviour).
- Sits between multiple producers (register-file read ports, bus masters) and one shared consumer.
- One-deep output register; one cycle of latency.

---
 rtl/rr_mux_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/rr_mux_mxn.sv | 110 +++++++++++
 tb/tb_rr_mux_mxn.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_pkg
//  Purpose  : Shared mode encodings and the circular first-set search helper
//             used by the round-robin multiplexer and its arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rr_mux_pkg;

    // Operating modes of the multiplexer
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Widest request vector the search helper accepts
    localparam int MAX_CH = 64;

    // Index of the first set bit of req[n-1:0] scanning start, start+1, ...
    // modulo n; returns -1 when no bit is set.
    function automatic int first_set_from(input logic [MAX_CH-1:0] req,
                                          input int n,
                                          input int start);
        int result;
        int k;
        result = -1;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < n && result < 0) begin
                k = (start + i) % n;
                if (req[6'(k)]) begin
                    result = k;
                end
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational grant selection: round-robin from ptr+1, or a
//             fixed select index. With RR_MUX_LOCK_EN defined, an active
//             lock restricts the grant to the locked channel in both modes.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int S_LINES = 2,
    parameter int N       = 2**S_LINES
) (
    input  logic [N-1:0]       req,
    input  logic [S_LINES-1:0] ptr,
    input  logic               mode,
    input  logic [S_LINES-1:0] sel,
`ifdef RR_MUX_LOCK_EN
    input  logic               lock_active,
    input  logic [S_LINES-1:0] lock_ch,
`endif
    output logic [S_LINES-1:0] grant_idx,
    output logic               grant_valid
);

    logic [S_LINES-1:0] start_idx;
    int                 rr_pick;

    // Search begins one past the last winner; the S_LINES-bit add wraps N-1 to 0
    assign start_idx = ptr + 1'b1;

    // Pick the grant for the current mode (and lock state, when enabled)
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        rr_pick     = first_set_from(MAX_CH'(req), N, int'(start_idx));
`ifdef RR_MUX_LOCK_EN
        if (lock_active) begin
            grant_idx   = lock_ch;
            grant_valid = req[lock_ch];
        end else
`endif
        if (mode == MODE_FIXED) begin
            grant_idx   = sel;
            grant_valid = req[sel];
        end else if (rr_pick >= 0) begin
            grant_idx   = S_LINES'(rr_pick);
            grant_valid = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_mux_mxn.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_mxn
//  Purpose  : Registered N:1 multiplexer with valid/ready on every input
//             channel and on the output. Round-robin or fixed-select mode,
//             one-deep output register, one cycle of latency, 1 beat/cycle.
//  Options  : RR_MUX_LOCK_EN adds in_last/out_last and packet locking.
//  Revision : 1.0  initial release
// ============================================================================
module rr_mux_mxn
    import rr_mux_pkg::*;
#(
    parameter int S_LINES = 2,
    parameter int D_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [D_WIDTH*(2**S_LINES)-1:0] in_data,
    input  logic [(2**S_LINES)-1:0]       in_valid,
    output logic [(2**S_LINES)-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [(2**S_LINES)-1:0]       in_last,
    output logic                          out_last,
`endif
    input  logic                          mode,
    input  logic [S_LINES-1:0]            sel,
    output logic [D_WIDTH-1:0]            out_data,
    output logic                          out_valid,
    output logic [S_LINES-1:0]            out_sel,
    input  logic                          out_ready
);

    localparam int N = 2**S_LINES;

    logic [D_WIDTH-1:0] chan_data [N];
    logic [S_LINES-1:0] ptr;
    logic [S_LINES-1:0] grant_idx;
    logic               grant_valid;
    logic               load;
    logic               take;

`ifdef RR_MUX_LOCK_EN
    logic               lock_active;
    logic [S_LINES-1:0] lock_ch;
`endif

    // Split the flat input bus into per-channel words
    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan_data[k] = in_data[D_WIDTH*k +: D_WIDTH];
    end

    // Output register can accept a new beat when empty or being drained
    assign load = !out_valid || out_ready;
    assign take = rst_n && load && grant_valid;

    rr_arbiter #(
        .S_LINES (S_LINES),
        .N       (N)
    ) u_arbiter (
        .req         (in_valid),
        .ptr         (ptr),
        .mode        (mode),
        .sel         (sel),
`ifdef RR_MUX_LOCK_EN
        .lock_active (lock_active),
        .lock_ch     (lock_ch),
`endif
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // One-hot accept to the granted producer, only when the beat is taken
    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register, priority pointer and lock state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel     <= '0;
            ptr         <= '1;
`ifdef RR_MUX_LOCK_EN
            out_last    <= 1'b0;
            lock_active <= 1'b0;
            lock_ch     <= '0;
`endif
        end else if (load) begin
            if (grant_valid) begin
                out_valid   <= 1'b1;
                out_data    <= chan_data[grant_idx];
                out_sel     <= grant_idx;
                ptr         <= grant_idx;
`ifdef RR_MUX_LOCK_EN
                out_last    <= in_last[grant_idx];
                lock_active <= !in_last[grant_idx];
                lock_ch     <= grant_idx;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_mxn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux_mxn
//  Purpose  : Self-checking bench for rr_mux_mxn: directed scenarios followed
//             by random traffic, all compared against a behavioural model.
//  Options  : RR_MUX_LOCK_EN enables the packet-lock model and ports.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_mux_mxn;

    localparam int S_LINES = 2;
    localparam int D_WIDTH = 8;
    localparam int N       = 4;
`ifdef RR_MUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [D_WIDTH*N-1:0]   in_data;
    logic [N-1:0]           in_valid;
    logic [N-1:0]           in_ready;
    logic [N-1:0]           in_last;
    logic                   out_last_w;
    logic                   mode;
    logic [S_LINES-1:0]     sel;
    logic [D_WIDTH-1:0]     out_data;
    logic                   out_valid;
    logic [S_LINES-1:0]     out_sel;
    logic                   out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_ptr;
    bit m_valid;
    int m_data;
    int m_sel;
    bit m_last;
    bit m_lock;
    int m_lock_ch;

    always #5 clk = ~clk;

    rr_mux_mxn #(
        .S_LINES (S_LINES),
        .D_WIDTH (D_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last_w),
`endif
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

`ifndef RR_MUX_LOCK_EN
    assign out_last_w = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Which channel the specification says should win this cycle (-1: none)
    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (LOCK_EN && m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode == 1'b1) return in_valid[sel] ? int'(sel) : -1;
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (in_valid[k]) return k;
        end
        return -1;
    endfunction

    // Apply inputs (called just after a falling edge)
    task automatic drive(input logic rn, input logic [N-1:0] v, input logic md,
                         input logic [S_LINES-1:0] s, input logic ordy,
                         input logic [D_WIDTH*N-1:0] d, input logic [N-1:0] lst);
        rst_n     = rn;
        in_valid  = v;
        mode      = md;
        sel       = s;
        out_ready = ordy;
        in_data   = d;
        in_last   = lst;
    endtask

    // Check in_ready, clock once, advance the model and check the outputs
    task automatic run_cycle();
        int g;
        bit ld;
        int gdata;
        bit glast;
        #1;
        g  = model_grant();
        ld = !m_valid || out_ready;
        check("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        gdata = (g >= 0) ? int'((in_data >> (g*D_WIDTH)) & 32'hFF) : 0;
        glast = (g >= 0) ? in_last[g] : 1'b0;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_ptr = N-1;
            m_last = 0; m_lock = 0; m_lock_ch = 0;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1; m_data = gdata; m_sel = g; m_ptr = g;
                m_last = glast; m_lock = !glast; m_lock_ch = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_sel",   32'(out_sel),   32'(m_sel));
        if (LOCK_EN) check("out_last", 32'(out_last_w), 32'(m_last));
        @(negedge clk);
    endtask

    initial begin
        logic [D_WIDTH*N-1:0] rr_data;
        logic [D_WIDTH*N-1:0] rnd_data;
        int exp_sel [5];
        int exp_dat [5];
        exp_sel = '{0, 1, 2, 3, 0};
        exp_dat = '{'h10, 'h21, 'h32, 'h43, 'h10};
        rr_data = 32'h4332_2110;

        m_ptr = N-1; m_valid = 0; m_data = 0; m_sel = 0;
        m_last = 0; m_lock = 0; m_lock_ch = 0;

        drive(1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, rr_data, 4'b1111);
        @(negedge clk);

        // Reset held two cycles with every channel requesting
        run_cycle();
        run_cycle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);

        // Full round-robin sweep including wrap back to channel 0
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, rr_data, 4'b1111);
            run_cycle();
            check("rr_seq_sel",  32'(out_sel),  32'(exp_sel[i]));
            check("rr_seq_data", 32'(out_data), 32'(exp_dat[i]));
        end

        // Back-pressure: output held, no accepts, then resume at ptr+1
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, rr_data, 4'b1111);
            run_cycle();
            check("hold_sel", 32'(out_sel), 32'd0);
        end
        drive(1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, rr_data, 4'b1111);
        run_cycle();
        check("resume_sel", 32'(out_sel), 32'd1);

        // Fixed select on an idle channel, then it becomes valid
        drive(1'b1, 4'b1011, 1'b1, 2'd2, 1'b1, 32'h435A_2110, 4'b1111);
        run_cycle();
        check("fixed_idle_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 4'b1111, 1'b1, 2'd2, 1'b1, 32'h435A_2110, 4'b1111);
        run_cycle();
        check("fixed_data", 32'(out_data), 32'h5A);
        check("fixed_sel",  32'(out_sel),  32'd2);

        // Sparse requests wrapping from channel 3 to channel 0
        drive(1'b1, 4'b1000, 1'b0, 2'd0, 1'b1, rr_data, 4'b1111);
        run_cycle();
        check("sparse_sel3", 32'(out_sel), 32'd3);
        drive(1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, rr_data, 4'b1111);
        run_cycle();
        check("sparse_sel0",   32'(out_sel),   32'd0);
        check("sparse_nobub",  32'(out_valid), 32'd1);

        // Packet lock: channel 1 sends three beats while channel 2 waits
        if (LOCK_EN) begin
            drive(1'b1, 4'b0010, 1'b0, 2'd0, 1'b1, rr_data, 4'b0000);
            run_cycle();
            drive(1'b1, 4'b0110, 1'b0, 2'd0, 1'b1, rr_data, 4'b0000);
            run_cycle();
            check("lock_beat2_sel", 32'(out_sel), 32'd1);
            drive(1'b1, 4'b0110, 1'b0, 2'd0, 1'b1, rr_data, 4'b0010);
            run_cycle();
            check("lock_beat3_sel",  32'(out_sel),    32'd1);
            check("lock_beat3_last", 32'(out_last_w), 32'd1);
            drive(1'b1, 4'b0100, 1'b0, 2'd0, 1'b1, rr_data, 4'b0100);
            run_cycle();
            check("lock_release_sel", 32'(out_sel), 32'd2);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_data = $urandom();
            drive(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                  N'($urandom()),
                  1'($urandom_range(0, 3) == 0),
                  S_LINES'($urandom()),
                  1'($urandom_range(0, 9) < 7),
                  rnd_data,
                  N'($urandom()));
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
